// File: rtl/rx_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl_if
// Bundles every non-clock/reset signal of the UART command controller:
//   RX side : RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR        (into ctrl)
//   RF side : RF_Address, RF_WrEn, RF_RdEn, RF_WrData           (from ctrl)
//             RF_RdData, RF_RdData_Valid                        (into ctrl)
//   ALU side: ALU_FUN, ALU_EN, CLK_GATE_EN                      (from ctrl)
//             ALU_OUT, ALU_OUT_VLD                              (into ctrl)
//   TX side : TX_P_DATA, TX_D_VLD                               (from ctrl)
//             TX_BUSY                                           (into ctrl)
//   CMD_ERR : one-cycle error pulse                             (from ctrl)
// modport master : the controller itself.
// modport slave  : the surrounding UART / register file / ALU.
// Width parameters must match those of the rx_cmd_ctrl instance using it.
// -----------------------------------------------------------------------------
interface rx_cmd_ctrl_if #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 4
);
  logic [Data_Width-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic                    RX_PAR_ERR;
  logic                    RX_STP_ERR;

  logic [Addr_Width-1:0]   RF_Address;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [Data_Width-1:0]   RF_WrData;
  logic [Data_Width-1:0]   RF_RdData;
  logic                    RF_RdData_Valid;

  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic                    CLK_GATE_EN;
  logic [2*Data_Width-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;

  logic [Data_Width-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TX_BUSY;

  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
    input  RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    output ALU_FUN, ALU_EN, CLK_GATE_EN,
    output TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RX_PAR_ERR, RX_STP_ERR,
    output RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData,
    input  ALU_FUN, ALU_EN, CLK_GATE_EN,
    input  TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl
// Decodes byte commands arriving from a UART receiver and drives a register
// file, an ALU and the UART transmitter:
//   0xAA addr data     : register-file write
//   0xBB addr          : register-file read, read byte sent back on TX
//   0xCC opA opB fun   : write opA->RF[0], opB->RF[1], run ALU, send result
//   0xDD fun           : run ALU on current RF[0]/RF[1], send result
// Result bytes go out LSB first. Any framing-error byte or unknown opcode
// aborts to IDLE with a one-cycle CMD_ERR; clean bytes arriving while the
// controller is waiting on RF/ALU/TX are dropped with CMD_ERR.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : rx_cmd_ctrl_if.master, all RX/RF/ALU/TX signals
// Every output is a flop; nothing combinational reaches the bus outputs.
// -----------------------------------------------------------------------------
module rx_cmd_ctrl #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 4
) (
  input  logic          CLK,
  input  logic          RST,
  rx_cmd_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_OPA, S_OPB, S_FUN, S_ALU_WAIT, S_TX_REQ, S_TX_HOLD
  } state_t;

  localparam logic [Data_Width-1:0] OP_RF_WR  = Data_Width'(8'hAA);
  localparam logic [Data_Width-1:0] OP_RF_RD  = Data_Width'(8'hBB);
  localparam logic [Data_Width-1:0] OP_ALU_OP = Data_Width'(8'hCC);
  localparam logic [Data_Width-1:0] OP_ALU_NO = Data_Width'(8'hDD);

  state_t                  r_state, w_state_nxt;

  logic [Addr_Width-1:0]   r_rf_address,  w_rf_address_nxt;
  logic                    r_rf_wren,     w_rf_wren_nxt;
  logic                    r_rf_rden,     w_rf_rden_nxt;
  logic [Data_Width-1:0]   r_rf_wrdata,   w_rf_wrdata_nxt;
  logic [3:0]              r_alu_fun,     w_alu_fun_nxt;
  logic                    r_alu_en,      w_alu_en_nxt;
  logic                    r_clk_gate_en, w_clk_gate_en_nxt;
  logic [Data_Width-1:0]   r_tx_p_data,   w_tx_p_data_nxt;
  logic                    r_tx_d_vld,    w_tx_d_vld_nxt;
  logic                    r_cmd_err,     w_cmd_err_nxt;
  // Pending TX bytes, current one in the low byte; r_tx_left counts them.
  logic [2*Data_Width-1:0] r_tx_buf,      w_tx_buf_nxt;
  logic [1:0]              r_tx_left,     w_tx_left_nxt;

  logic w_byte_ok, w_byte_bad, w_is_cmd;

  assign w_byte_ok  = bus.RX_D_VLD & ~(bus.RX_PAR_ERR | bus.RX_STP_ERR);
  assign w_byte_bad = bus.RX_D_VLD &  (bus.RX_PAR_ERR | bus.RX_STP_ERR);
  assign w_is_cmd   = (bus.RX_P_DATA == OP_RF_WR)  || (bus.RX_P_DATA == OP_RF_RD) ||
                      (bus.RX_P_DATA == OP_ALU_OP) || (bus.RX_P_DATA == OP_ALU_NO);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A framing-error byte aborts from any state.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (which would infer a latch).
    w_state_nxt = r_state;
    if (w_byte_bad) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_byte_ok) begin
          if      (bus.RX_P_DATA == OP_RF_WR)  w_state_nxt = S_WR_ADDR;
          else if (bus.RX_P_DATA == OP_RF_RD)  w_state_nxt = S_RD_ADDR;
          else if (bus.RX_P_DATA == OP_ALU_OP) w_state_nxt = S_OPA;
          else if (bus.RX_P_DATA == OP_ALU_NO) w_state_nxt = S_FUN;
        end
        S_WR_ADDR:  if (w_byte_ok) w_state_nxt = S_WR_DATA;
        S_WR_DATA:  if (w_byte_ok) w_state_nxt = S_IDLE;
        S_RD_ADDR:  if (w_byte_ok) w_state_nxt = S_RD_WAIT;
        S_RD_WAIT:  if (bus.RF_RdData_Valid) w_state_nxt = S_TX_REQ;
        S_OPA:      if (w_byte_ok) w_state_nxt = S_OPB;
        S_OPB:      if (w_byte_ok) w_state_nxt = S_FUN;
        S_FUN:      if (w_byte_ok) w_state_nxt = S_ALU_WAIT;
        S_ALU_WAIT: if (bus.ALU_OUT_VLD) w_state_nxt = S_TX_REQ;
        // Leave TX_REQ only once our request has been acknowledged by BUSY.
        S_TX_REQ:   if (r_tx_d_vld && bus.TX_BUSY) w_state_nxt = S_TX_HOLD;
        S_TX_HOLD:  if (!bus.TX_BUSY) w_state_nxt = (r_tx_left > 2'd1) ? S_TX_REQ : S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the output registers. Strobes default low every cycle;
  // buses and levels hold unless a state updates them.
  always_comb begin
    w_rf_address_nxt  = r_rf_address;
    w_rf_wren_nxt     = 1'b0;
    w_rf_rden_nxt     = 1'b0;
    w_rf_wrdata_nxt   = r_rf_wrdata;
    w_alu_fun_nxt     = r_alu_fun;
    w_alu_en_nxt      = 1'b0;
    w_clk_gate_en_nxt = r_clk_gate_en;
    w_tx_p_data_nxt   = r_tx_p_data;
    w_tx_d_vld_nxt    = r_tx_d_vld;
    w_cmd_err_nxt     = 1'b0;
    w_tx_buf_nxt      = r_tx_buf;
    w_tx_left_nxt     = r_tx_left;

    if (w_byte_bad) begin
      // Abort: drop the byte and release anything held open.
      w_cmd_err_nxt     = 1'b1;
      w_clk_gate_en_nxt = 1'b0;
      w_tx_d_vld_nxt    = 1'b0;
      w_tx_left_nxt     = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_byte_ok && !w_is_cmd) w_cmd_err_nxt = 1'b1;
        S_WR_ADDR: if (w_byte_ok) w_rf_address_nxt = bus.RX_P_DATA[Addr_Width-1:0];
        S_WR_DATA: if (w_byte_ok) begin
          w_rf_wrdata_nxt = bus.RX_P_DATA;
          w_rf_wren_nxt   = 1'b1;
        end
        S_RD_ADDR: if (w_byte_ok) begin
          w_rf_address_nxt = bus.RX_P_DATA[Addr_Width-1:0];
          w_rf_rden_nxt    = 1'b1;
        end
        S_RD_WAIT: begin
          if (bus.RX_D_VLD) w_cmd_err_nxt = 1'b1;
          if (bus.RF_RdData_Valid) begin
            w_tx_buf_nxt  = {{Data_Width{1'b0}}, bus.RF_RdData};
            w_tx_left_nxt = 2'd1;
          end
        end
        S_OPA: if (w_byte_ok) begin
          w_rf_address_nxt = '0;
          w_rf_wrdata_nxt  = bus.RX_P_DATA;
          w_rf_wren_nxt    = 1'b1;
        end
        S_OPB: if (w_byte_ok) begin
          w_rf_address_nxt = Addr_Width'(1);
          w_rf_wrdata_nxt  = bus.RX_P_DATA;
          w_rf_wren_nxt    = 1'b1;
        end
        S_FUN: if (w_byte_ok) begin
          w_alu_fun_nxt     = bus.RX_P_DATA[3:0];
          w_alu_en_nxt      = 1'b1;
          w_clk_gate_en_nxt = 1'b1;
        end
        S_ALU_WAIT: begin
          if (bus.RX_D_VLD) w_cmd_err_nxt = 1'b1;
          // Gate stays open through the cycle the result strobe is seen.
          if (bus.ALU_OUT_VLD) begin
            w_clk_gate_en_nxt = 1'b0;
            w_tx_buf_nxt      = bus.ALU_OUT;
            w_tx_left_nxt     = 2'd2;
          end
        end
        S_TX_REQ: begin
          if (bus.RX_D_VLD) w_cmd_err_nxt = 1'b1;
          if (!r_tx_d_vld) begin
            if (!bus.TX_BUSY) begin
              w_tx_p_data_nxt = r_tx_buf[Data_Width-1:0];
              w_tx_d_vld_nxt  = 1'b1;
            end
          end else if (bus.TX_BUSY) begin
            w_tx_d_vld_nxt = 1'b0;
          end
        end
        S_TX_HOLD: begin
          if (bus.RX_D_VLD) w_cmd_err_nxt = 1'b1;
          if (!bus.TX_BUSY) begin
            w_tx_buf_nxt  = r_tx_buf >> Data_Width;
            w_tx_left_nxt = r_tx_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every register here, including the TX byte buffer, is cleared by
  // reset so no stale command data survives an aborted transaction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rf_address  <= '0;
      r_rf_wren     <= 1'b0;
      r_rf_rden     <= 1'b0;
      r_rf_wrdata   <= '0;
      r_alu_fun     <= '0;
      r_alu_en      <= 1'b0;
      r_clk_gate_en <= 1'b0;
      r_tx_p_data   <= '0;
      r_tx_d_vld    <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_tx_buf      <= '0;
      r_tx_left     <= 2'd0;
    end else begin
      r_rf_address  <= w_rf_address_nxt;
      r_rf_wren     <= w_rf_wren_nxt;
      r_rf_rden     <= w_rf_rden_nxt;
      r_rf_wrdata   <= w_rf_wrdata_nxt;
      r_alu_fun     <= w_alu_fun_nxt;
      r_alu_en      <= w_alu_en_nxt;
      r_clk_gate_en <= w_clk_gate_en_nxt;
      r_tx_p_data   <= w_tx_p_data_nxt;
      r_tx_d_vld    <= w_tx_d_vld_nxt;
      r_cmd_err     <= w_cmd_err_nxt;
      r_tx_buf      <= w_tx_buf_nxt;
      r_tx_left     <= w_tx_left_nxt;
    end
  end

  assign bus.RF_Address  = r_rf_address;
  assign bus.RF_WrEn     = r_rf_wren;
  assign bus.RF_RdEn     = r_rf_rden;
  assign bus.RF_WrData   = r_rf_wrdata;
  assign bus.ALU_FUN     = r_alu_fun;
  assign bus.ALU_EN      = r_alu_en;
  assign bus.CLK_GATE_EN = r_clk_gate_en;
  assign bus.TX_P_DATA   = r_tx_p_data;
  assign bus.TX_D_VLD    = r_tx_d_vld;
  assign bus.CMD_ERR     = r_cmd_err;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_cmd_ctrl
// The bench plays the UART receiver, register file, ALU and transmitter.
// Expected RF writes/reads, ALU starts, TX bytes and error pulses for each
// command are derived from the command bytes alone, and compared against
// what the monitors record on the bus.
// -----------------------------------------------------------------------------
module tb_rx_cmd_ctrl;

  localparam logic [7:0] OP_WR = 8'hAA;
  localparam logic [7:0] OP_RD = 8'hBB;
  localparam logic [7:0] OP_CC = 8'hCC;
  localparam logic [7:0] OP_DD = 8'hDD;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  rx_cmd_ctrl_if #(.Data_Width(8), .Addr_Width(4)) bus ();
  rx_cmd_ctrl #(.Data_Width(8), .Addr_Width(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Environment state: the external register file and observed events.
  logic [7:0]  rf_mem   [16] = '{default: 8'h00};
  logic [11:0] wr_q     [$];
  logic [3:0]  rd_q     [$];
  logic [3:0]  alu_q    [$];
  logic [7:0]  tx_q     [$];
  int          err_cnt  = 0;
  int          tx_done  = 0;

  // Reference model: what the RF should hold, and per-command expectations.
  logic [7:0]  model_rf [16] = '{default: 8'h00};
  logic [11:0] exp_wr   [$];
  logic [3:0]  exp_rd   [$];
  logic [3:0]  exp_alu  [$];
  logic [7:0]  exp_tx   [$];
  int          exp_err  = 0;

  // Responder knobs.
  int   rd_delay  = 2;
  int   alu_fixed = 0;
  logic alu_hold  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The ALU living outside the controller.
  function automatic logic [15:0] env_alu(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h0:    return 16'(a) * 16'(b);
      4'h1:    return 16'(a) + 16'(b);
      4'h2:    return 16'(a) - 16'(b);
      default: return {a ^ {4'h0, f}, b};
    endcase
  endfunction

  // Bus monitor and register-file storage.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.RF_WrEn) begin
        wr_q.push_back({bus.RF_Address, bus.RF_WrData});
        rf_mem[bus.RF_Address] = bus.RF_WrData;
      end
      if (bus.RF_RdEn) rd_q.push_back(bus.RF_Address);
      if (bus.ALU_EN)  alu_q.push_back(bus.ALU_FUN);
      if (bus.CMD_ERR) err_cnt++;
    end
  end

  // Register-file read responder.
  initial begin
    bus.RF_RdData = '0;
    bus.RF_RdData_Valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && bus.RF_RdEn) begin
        repeat (rd_delay) @(negedge CLK);
        bus.RF_RdData = rf_mem[bus.RF_Address];
        bus.RF_RdData_Valid = 1'b1;
        @(negedge CLK);
        bus.RF_RdData_Valid = 1'b0;
      end
    end
  end

  // ALU responder; also checks the clock gate is open while it works.
  initial begin
    bus.ALU_OUT = '0;
    bus.ALU_OUT_VLD = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && bus.ALU_EN) begin
        if (alu_hold) begin
          while (alu_hold) @(negedge CLK);
          bus.ALU_OUT = env_alu(bus.ALU_FUN, rf_mem[0], rf_mem[1]);
          bus.ALU_OUT_VLD = 1'b1;
          @(negedge CLK);
          bus.ALU_OUT_VLD = 1'b0;
        end else begin
          check("gate_at_alu_en", bus.CLK_GATE_EN, 1);
          repeat ((alu_fixed > 0) ? alu_fixed : $urandom_range(1, 4)) begin
            @(negedge CLK);
            check("gate_during_alu", bus.CLK_GATE_EN, 1);
          end
          bus.ALU_OUT = env_alu(bus.ALU_FUN, rf_mem[0], rf_mem[1]);
          bus.ALU_OUT_VLD = 1'b1;
          @(negedge CLK);
          bus.ALU_OUT_VLD = 1'b0;
          check("gate_after_alu", bus.CLK_GATE_EN, 0);
        end
      end
    end
  end

  // Transmitter: accepts a byte after a random lag, stays busy a while.
  initial begin
    logic [7:0] byte_seen;
    bus.TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && bus.TX_D_VLD && !bus.TX_BUSY) begin
        byte_seen = bus.TX_P_DATA;
        tx_q.push_back(byte_seen);
        repeat ($urandom_range(0, 2)) begin
          @(negedge CLK);
          check("tx_vld_held", bus.TX_D_VLD, 1);
          check("tx_data_held", bus.TX_P_DATA, byte_seen);
        end
        bus.TX_BUSY = 1'b1;
        @(negedge CLK);
        check("tx_vld_drop", bus.TX_D_VLD, 0);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        bus.TX_BUSY = 1'b0;
        tx_done++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_outs_zero(input string tag);
    check(tag, {bus.RF_Address, bus.RF_WrEn, bus.RF_RdEn, bus.RF_WrData, bus.ALU_FUN,
                bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR}, 0);
  endtask

  // One received byte: RX_D_VLD high for one cycle, then a random idle gap.
  task automatic send_byte(input logic [7:0] b, input logic par, input logic stp);
    bus.RX_P_DATA  = b;
    bus.RX_D_VLD   = 1'b1;
    bus.RX_PAR_ERR = par;
    bus.RX_STP_ERR = stp;
    @(negedge CLK);
    bus.RX_D_VLD   = 1'b0;
    bus.RX_PAR_ERR = 1'b0;
    bus.RX_STP_ERR = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  task automatic expect_alu(input logic [7:0] f);
    logic [15:0] res;
    exp_alu.push_back(f[3:0]);
    res = env_alu(f[3:0], model_rf[0], model_rf[1]);
    exp_tx.push_back(res[7:0]);
    exp_tx.push_back(res[15:8]);
  endtask

  // Wait for the expected TX traffic, then compare everything recorded.
  task automatic finish_cmd(input string tag);
    int target;
    int waited;
    target = tx_done + exp_tx.size();
    waited = 0;
    while (tx_done < target && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    if (exp_tx.size() > 0) check({tag, "_tx_done"}, 32'(tx_done >= target), 1);
    repeat (4) @(negedge CLK);
    check({tag, "_n_wr"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) check({tag, "_wr"}, wr_q[i], exp_wr[i]);
    check({tag, "_n_rd"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) check({tag, "_rd"}, rd_q[i], exp_rd[i]);
    check({tag, "_n_alu"}, alu_q.size(), exp_alu.size());
    for (int i = 0; i < exp_alu.size() && i < alu_q.size(); i++) check({tag, "_alu"}, alu_q[i], exp_alu[i]);
    check({tag, "_n_tx"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) check({tag, "_tx"}, tx_q[i], exp_tx[i]);
    check({tag, "_err"}, err_cnt, exp_err);
    wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); err_cnt = 0;
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete(); exp_err = 0;
  endtask

  // Send one command; err_idx (if inside the command) marks the byte that
  // carries a framing error, after which the command is abandoned.
  task automatic do_cmd(input string tag, input logic [7:0] op, input logic [7:0] p0,
                        input logic [7:0] p1, input logic [7:0] p2, input int err_idx);
    logic [7:0] b[$];
    int         eidx;
    logic [1:0] eflags;
    b.push_back(op);
    case (op)
      OP_WR:   begin b.push_back(p0); b.push_back(p1); end
      OP_RD:   b.push_back(p0);
      OP_CC:   begin b.push_back(p0); b.push_back(p1); b.push_back(p2); end
      OP_DD:   b.push_back(p0);
      default: ;
    endcase
    eidx = (err_idx >= 0 && err_idx < b.size()) ? err_idx : -1;
    if (eidx >= 0) begin
      exp_err = 1;
      if (op == OP_CC && eidx >= 2) begin exp_wr.push_back({4'h0, p0}); model_rf[0] = p0; end
      if (op == OP_CC && eidx >= 3) begin exp_wr.push_back({4'h1, p1}); model_rf[1] = p1; end
    end else begin
      case (op)
        OP_WR: begin exp_wr.push_back({p0[3:0], p1}); model_rf[p0[3:0]] = p1; end
        OP_RD: begin exp_rd.push_back(p0[3:0]); exp_tx.push_back(model_rf[p0[3:0]]); end
        OP_CC: begin
          exp_wr.push_back({4'h0, p0}); model_rf[0] = p0;
          exp_wr.push_back({4'h1, p1}); model_rf[1] = p1;
          expect_alu(p2);
        end
        OP_DD:   expect_alu(p0);
        default: exp_err = 1;
      endcase
    end
    for (int i = 0; i < b.size(); i++) begin
      if (eidx >= 0 && i > eidx) break;
      eflags = (i == eidx) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_byte(b[i], eflags[0], eflags[1]);
    end
    finish_cmd(tag);
  endtask

  initial begin
    logic [7:0] op;
    int         sel;
    bus.RX_P_DATA  = '0;
    bus.RX_D_VLD   = 1'b0;
    bus.RX_PAR_ERR = 1'b0;
    bus.RX_STP_ERR = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_outs_zero("reset_outputs");
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_outs_zero("idle_outputs");

    // Directed: basic write, read-back, ALU with operands, unknown opcode.
    do_cmd("wr_basic", OP_WR, 8'h05, 8'h3C, 8'h00, -1);
    do_cmd("rd_basic", OP_RD, 8'h05, 8'h00, 8'h00, -1);
    do_cmd("alu_cc",   OP_CC, 8'h10, 8'h20, 8'h01, -1);
    check("rf0_after_cc", rf_mem[0], 8'h10);
    check("rf1_after_cc", rf_mem[1], 8'h20);
    check("alu_fun_out", bus.ALU_FUN, 4'h1);
    do_cmd("bad_op",   8'h55, 8'h00, 8'h00, 8'h00, -1);
    check("bad_op_no_wr", bus.RF_WrEn, 0);

    // Stop-bit error on the data byte, then a clean write.
    exp_err = 1;
    send_byte(OP_WR, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1);
    finish_cmd("wr_stp_err");
    do_cmd("wr_after_err", OP_WR, 8'h05, 8'hA5, 8'h00, -1);

    // Clean byte while waiting for RF read data: dropped, read completes.
    rd_delay = 6;
    exp_rd.push_back(4'h5); exp_tx.push_back(model_rf[5]); exp_err = 1;
    send_byte(OP_RD, 1'b0, 1'b0);
    bus.RX_P_DATA = 8'h05; bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    @(negedge CLK);
    send_byte(8'h11, 1'b0, 1'b0);
    finish_cmd("rd_wait_junk");

    // Framing-error byte while waiting: abort, late read data ignored.
    exp_rd.push_back(4'h5); exp_err = 1;
    send_byte(OP_RD, 1'b0, 1'b0);
    bus.RX_P_DATA = 8'h05; bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    @(negedge CLK);
    send_byte(8'h22, 1'b1, 1'b0);
    repeat (8) @(negedge CLK);
    finish_cmd("rd_wait_abort");
    rd_delay = 2;

    // Clean byte during ALU_WAIT: dropped, result still transmitted.
    alu_fixed = 6;
    expect_alu(8'h02); exp_err = 1;
    send_byte(OP_DD, 1'b0, 1'b0);
    bus.RX_P_DATA = 8'h02; bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    @(negedge CLK);
    send_byte(8'h33, 1'b0, 1'b0);
    finish_cmd("alu_wait_junk");
    alu_fixed = 0;

    // Randomised command mix with occasional framing errors.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if      (sel < 2) op = OP_WR;
      else if (sel < 4) op = OP_RD;
      else if (sel < 6) op = OP_CC;
      else if (sel < 8) op = OP_DD;
      else begin
        op = 8'($urandom);
        while (op == OP_WR || op == OP_RD || op == OP_CC || op == OP_DD) op = 8'($urandom);
      end
      do_cmd($sformatf("rnd%0d", k), op, 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // Reset while the ALU is running with the clock gate open.
    alu_hold = 1'b1;
    exp_alu.push_back(4'h3);
    send_byte(OP_DD, 1'b0, 1'b0);
    bus.RX_P_DATA = 8'h03; bus.RX_D_VLD = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    check("gate_before_rst", bus.CLK_GATE_EN, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_outs_zero("rst_mid_alu");
    RST = 1'b0;
    alu_hold = 1'b0;
    repeat (6) @(negedge CLK);
    check("gate_after_late_vld", bus.CLK_GATE_EN, 0);
    check("tx_after_late_vld", bus.TX_D_VLD, 0);
    finish_cmd("rst_alu");
    do_cmd("wr_after_rst", OP_WR, 8'h02, 8'h55, 8'h00, -1);
    check("rf2_after_rst", rf_mem[2], 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: RX_CMD_CTRL

Interface
REQ-001 SHALL have parameter Data_Width, default 8, byte width of the UART payload.
REQ-002 SHALL have parameter Addr_Width, default 4, register-file address width.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RX_P_DATA  input  Data_Width  received byte from the UART receiver.
REQ-006 SHALL have port RX_D_VLD  input  1  one-cycle pulse: RX_P_DATA valid.
REQ-007 SHALL have port RX_PAR_ERR / RX_STP_ERR  input  1 each  frame error flags, sampled with RX_D_VLD.
REQ-008 SHALL have port RF_Address  output  Addr_Width  register-file address.
REQ-009 SHALL have port RF_WrEn / RF_RdEn  output  1 each  one-cycle write/read strobes.
REQ-010 SHALL have port RF_WrData  output  Data_Width  write data.
REQ-011 SHALL have port RF_RdData  input  Data_Width  read data; RF_RdData_Valid  input  1  read-data strobe.
REQ-012 SHALL have port ALU_FUN  output  4  ALU opcode; ALU_EN  output  1  one-cycle start strobe; CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-013 SHALL have port ALU_OUT  input  2*Data_Width  result; ALU_OUT_VLD  input  1  result strobe.
REQ-014 SHALL have port TX_P_DATA  output  Data_Width  byte to transmitter; TX_D_VLD  output  1  byte request; TX_BUSY  input  1  transmitter busy.
REQ-015 SHALL have port CMD_ERR  output  1  one-cycle pulse on any dropped byte or aborted command.

Function
REQ-016 SHALL register every output; no output is combinational from inputs.
REQ-017 SHALL decode first byte in IDLE: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands; any other value -> stay IDLE, CMD_ERR pulse.
REQ-018 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_REQ, TX_HOLD.
REQ-019 SHALL advance byte-accepting states only on RX_D_VLD=1; state held otherwise, no timeout.
REQ-020 0xAA: WR_ADDR latches RF_Address = RX_P_DATA[Addr_Width-1:0]; WR_DATA drives RF_WrData and pulses RF_WrEn the cycle after the data byte's RX_D_VLD; -> IDLE.
REQ-021 0xBB: RD_ADDR latches RF_Address, pulses RF_RdEn the cycle after; RD_WAIT until RF_RdData_Valid, capture RF_RdData as one TX byte; -> TX_REQ.
REQ-022 0xCC: OPA byte written to RF address 0, OPB byte to address 1 (RF_WrEn pulse the cycle after each byte); -> FUN.
REQ-023 0xDD: goes directly to FUN.
REQ-024 FUN: ALU_FUN = RX_P_DATA[3:0]; ALU_EN pulses the cycle after the byte; CLK_GATE_EN high from that cycle through the cycle ALU_OUT_VLD is seen in ALU_WAIT; capture ALU_OUT; two TX bytes queued, LSB first.
REQ-025 TX_REQ: only when TX_BUSY=0, drive TX_P_DATA and hold TX_D_VLD=1 until TX_BUSY=1 observed; then TX_D_VLD=0, TX_HOLD until TX_BUSY=0; next byte or IDLE.
REQ-026 Byte with RX_PAR_ERR or RX_STP_ERR set SHALL be discarded: no RF/ALU/TX action, -> IDLE, CMD_ERR pulse; applies in every state.
REQ-027 RX_D_VLD in RD_WAIT, ALU_WAIT, TX_REQ, TX_HOLD SHALL drop the byte, pulse CMD_ERR, state unchanged.
REQ-028 RF_RdData_Valid / ALU_OUT_VLD outside their wait states SHALL be ignored.

Reset
REQ-029 RST=1 at a clock edge SHALL force IDLE and all outputs to 0 (buses 0, strobes 0, CLK_GATE_EN 0, TX_D_VLD 0) on that edge, including mid-command; partially received commands are discarded.
REQ-030 After reset release, the first RX_D_VLD SHALL be decoded as a command byte.

Verification
REQ-031 Bytes 0xAA,0x05,0x3C -> one RF_WrEn pulse, RF_Address=5, RF_WrData=0x3C; no TX, no CMD_ERR.
REQ-032 Bytes 0xBB,0x05; RF_RdData=0x3C with valid 2 cycles later -> RF_RdEn once, TX_D_VLD held until TX_BUSY=1, TX_P_DATA=0x3C, return IDLE.
REQ-033 Bytes 0xCC,0x10,0x20,0x01; ALU_OUT=0x0030 -> RF writes addr0=0x10, addr1=0x20, ALU_FUN=1, ALU_EN once, CLK_GATE_EN high until ALU_OUT_VLD, TX bytes 0x30 then 0x00.
REQ-034 Byte 0x55 in IDLE -> CMD_ERR pulse, no other outputs change.
REQ-035 0xAA,0x05, then data byte with RX_STP_ERR=1 -> no RF_WrEn, CMD_ERR pulse, next 0xAA command completes normally.
REQ-036 RST asserted during ALU_WAIT with CLK_GATE_EN=1 -> next cycle all outputs 0, state IDLE; late ALU_OUT_VLD ignored.
